// File: rtl/prbs8_check.sv
// prbs8_check: 8-lane PRBS31 (x^31+x^28+1) checker.
// Per-lane search/verify/lock FSM with windowed loss-of-lock.
module prbs8_check #(
  parameter int VERIFY_LEN = 64,
  parameter int LOSS_ERRS  = 8,
  parameter int LOSS_WIN   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  signal_in,
  input  logic        err_clr,
  output logic [7:0]  lock,
  output logic [7:0]  err_pulse,
  output logic [15:0] err_cnt
);

  localparam int MW = $clog2(VERIFY_LEN + 1);
  localparam int BW = $clog2(LOSS_ERRS + 1);
  localparam int WW = $clog2(LOSS_WIN);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  logic [7:0]  lock_d;
  logic [7:0]  pulse_d;
  logic [3:0]  pc;
  logic [16:0] sum;
  logic [15:0] cnt_d;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    state_t        st_q, st_d;
    logic [30:0]   h_q, h_d;
    logic [4:0]    fill_q, fill_d;
    logic [MW-1:0] m_q, m_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [WW-1:0] win_q, win_d;
    logic          r, p, mis;
    logic [30:0]   hs;

    assign r   = signal_in[7-i];
    assign p   = h_q[30] ^ h_q[27];
    assign mis = r ^ p;
    assign hs  = {h_q[29:0], r};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q   <= SEARCH;
        h_q    <= '0;
        fill_q <= '0;
        m_q    <= '0;
        bad_q  <= '0;
        win_q  <= '0;
      end else begin
        st_q   <= st_d;
        h_q    <= h_d;
        fill_q <= fill_d;
        m_q    <= m_d;
        bad_q  <= bad_d;
        win_q  <= win_d;
      end
    end

    always_comb begin
      st_d   = st_q;
      h_d    = h_q;
      fill_d = fill_q;
      m_d    = m_q;
      bad_d  = bad_q;
      win_d  = win_q;
      if (en) begin
        unique case (st_q)
          SEARCH: begin
            h_d = hs;
            if (fill_q == 5'd30) begin
              st_d   = VERIFY;
              fill_d = '0;
              m_d    = '0;
            end else begin
              fill_d = fill_q + 5'd1;
            end
          end
          VERIFY: begin
            h_d = hs;
            if (mis) begin
              st_d   = SEARCH;
              fill_d = '0;
            end else if (m_q == MW'(VERIFY_LEN - 1)) begin
              // an all-zero history is a dead line, not a PRBS
              st_d   = (hs == '0) ? SEARCH : LOCKED;
              fill_d = '0;
              m_d    = '0;
              bad_d  = '0;
              win_d  = '0;
            end else begin
              m_d = m_q + 1'b1;
            end
          end
          LOCKED: begin
            h_d   = {h_q[29:0], p};
            win_d = win_q + 1'b1;
            if (mis && bad_q == BW'(LOSS_ERRS - 1)) begin
              st_d   = SEARCH;
              fill_d = '0;
              bad_d  = '0;
              win_d  = '0;
            end else if (win_q == WW'(LOSS_WIN - 1)) begin
              bad_d = '0;
            end else if (mis) begin
              bad_d = bad_q + 1'b1;
            end
          end
          default: st_d = SEARCH;
        endcase
      end
    end

    assign lock_d[7-i]  = (st_d == LOCKED);
    assign pulse_d[7-i] = en && (st_q == LOCKED) && mis;
  end

  always_comb begin
    pc = '0;
    for (int k = 0; k < 8; k++) begin
      pc = pc + 4'(pulse_d[k]);
    end
  end

  assign sum   = {1'b0, err_cnt} + 17'(pc);
  assign cnt_d = sum[16] ? 16'hFFFF : sum[15:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock      <= '0;
      err_pulse <= '0;
      err_cnt   <= '0;
    end else begin
      lock      <= lock_d;
      err_pulse <= pulse_d;
      err_cnt   <= err_clr ? 16'h0000 : cnt_d;
    end
  end

endmodule
